fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit.sv | 91 +++++++++
 tb/tb_fetch_pc_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module      : fetch_pc_unit
// Description : IF-stage program counter and IF/ID pipeline register with
//               ID-stage branch/jump/jr redirect and a single delay slot.
//               Optional macro FETCH_ADDR_CHECK_EN enables the fetch address
//               error flag (adel_f); otherwise adel_f is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        br_true,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_addr,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        adel_f
);

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] C_IM_LO    = 32'h0000_3000;
    localparam logic [31:0] C_IM_HI    = 32'h0000_6FFC;
    localparam logic [1:0]  C_NPC_SEQ  = 2'b00;
    localparam logic [1:0]  C_NPC_BR   = 2'b01;
    localparam logic [1:0]  C_NPC_J    = 2'b10;
    localparam logic [1:0]  C_NPC_JR   = 2'b11;

    logic [31:0] r_pc_f;
    logic [31:0] r_pc_d;
    logic [31:0] r_instr_d;

    logic [31:0] w_pc_f_plus4;
    logic [31:0] w_pc_d_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_npc;

    // Targets are formed from the instruction sitting in ID, i.e. from pc_d.
    assign w_pc_f_plus4 = r_pc_f + 32'd4;
    assign w_pc_d_plus4 = r_pc_d + 32'd4;
    assign w_br_off     = {{14{imm16[15]}}, imm16, 2'b00};
    assign w_br_target  = w_pc_d_plus4 + w_br_off;
    assign w_j_target   = {w_pc_d_plus4[31:28], instr_index, 2'b00};

    always_comb begin
        w_npc = w_pc_f_plus4;
        case (npc_op)
            C_NPC_SEQ: w_npc = w_pc_f_plus4;
            C_NPC_BR:  w_npc = br_true ? w_br_target : w_pc_f_plus4;
            C_NPC_J:   w_npc = w_j_target;
            C_NPC_JR:  w_npc = jr_addr;
            default:   w_npc = w_pc_f_plus4;
        endcase
    end

    // No squash: the word fetched alongside a redirect always enters ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f    <= C_RESET_PC;
            r_pc_d    <= C_RESET_PC;
            r_instr_d <= 32'd0;
        end else if (!stall) begin
            r_pc_f    <= w_npc;
            r_pc_d    <= r_pc_f;
            r_instr_d <= instr_f;
        end
    end

    assign pc_f    = r_pc_f;
    assign pc_d    = r_pc_d;
    assign instr_d = r_instr_d;
    assign pc8_d   = r_pc_d + 32'd8;

`ifdef FETCH_ADDR_CHECK_EN
    assign adel_f = (r_pc_f[1:0] != 2'b00) || (r_pc_f < C_IM_LO) || (r_pc_f > C_IM_HI);
`else
    assign adel_f = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Scoreboard bench for fetch_pc_unit; expected IF/ID state is
//               queued when each cycle's stimulus is driven and popped after
//               the edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        br_true;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_addr;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        adel_f;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] pc_d;
        logic [31:0] instr_d;
        logic [31:0] pc8_d;
        logic        adel_f;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pc_f;
    logic [31:0] m_pc_d;
    logic [31:0] m_instr_d;

    fetch_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_op      (npc_op),
        .br_true     (br_true),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_addr     (jr_addr),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc8_d       (pc8_d),
        .adel_f      (adel_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic exp_adel(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
`else
        return 1'b0;
`endif
    endfunction

    assign instr_f = imem(pc_f);

    // Drive one cycle of stimulus, advance the reference model, queue the
    // expected post-edge state, then step past the edge.
    task automatic step(input logic rst, input logic st, input logic [1:0] op,
                        input logic br, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] jra);
        exp_t        x;
        logic [31:0] npc;
        logic [31:0] pd4;
        reset = rst; stall = st; npc_op = op; br_true = br;
        imm16 = imm; instr_index = idx; jr_addr = jra;
        pd4 = m_pc_d + 32'd4;
        case (op)
            2'b01:   npc = br ? pd4 + {{14{imm[15]}}, imm, 2'b00} : m_pc_f + 32'd4;
            2'b10:   npc = {pd4[31:28], idx, 2'b00};
            2'b11:   npc = jra;
            default: npc = m_pc_f + 32'd4;
        endcase
        if (rst) begin
            m_pc_f = 32'h3000; m_pc_d = 32'h3000; m_instr_d = 32'd0;
        end else if (!st) begin
            m_instr_d = imem(m_pc_f);
            m_pc_d    = m_pc_f;
            m_pc_f    = npc;
        end
        x.pc_f = m_pc_f; x.pc_d = m_pc_d; x.instr_d = m_instr_d;
        x.pc8_d = m_pc_d + 32'd8; x.adel_f = exp_adel(m_pc_f);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_f, pc_d, instr_d, pc8_d, adel_f} !== {e.pc_f, e.pc_d, e.instr_d, e.pc8_d, e.adel_f}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got pc_f=%h pc_d=%h instr_d=%h pc8_d=%h adel=%b want %h %h %h %h %b",
                         i, pc_f, pc_d, instr_d, pc8_d, adel_f, e.pc_f, e.pc_d, e.instr_d, e.pc8_d, e.adel_f);
            end
        end
    endtask

    task automatic test_sequential(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 2'b00, 1'b1, 16'hFFFC, 26'h3FF_FFFF, 32'hDEAD_BEEC);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_f, pc_d, instr_d, pc8_d, adel_f} !== {e.pc_f, e.pc_d, e.instr_d, e.pc8_d, e.adel_f}) begin
                n_bad++;
                $display("FAIL seq[%0d]: got pc_f=%h pc_d=%h instr_d=%h pc8_d=%h adel=%b want %h %h %h %h %b",
                         i, pc_f, pc_d, instr_d, pc8_d, adel_f, e.pc_f, e.pc_d, e.instr_d, e.pc8_d, e.adel_f);
            end
        end
    endtask

    task automatic test_branch();
        // Reach pc_d=0x3010, take a backward branch, then a not-taken one.
        test_reset();
        test_sequential(5);
        step(1'b0, 1'b0, 2'b01, 1'b1, 16'hFFFC, 26'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if (pc_f !== 32'h3004 || {pc_d, instr_d} !== {e.pc_d, e.instr_d}) begin
            n_bad++;
            $display("FAIL branch_taken: got pc_f=%h pc_d=%h instr_d=%h want %h %h %h",
                     pc_f, pc_d, instr_d, 32'h3004, e.pc_d, e.instr_d);
        end
        step(1'b0, 1'b0, 2'b01, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if ({pc_f, pc_d, instr_d} !== {e.pc_f, e.pc_d, e.instr_d}) begin
            n_bad++;
            $display("FAIL branch_not_taken: got pc_f=%h pc_d=%h instr_d=%h want %h %h %h",
                     pc_f, pc_d, instr_d, e.pc_f, e.pc_d, e.instr_d);
        end
    endtask

    task automatic test_jump();
        test_reset();
        test_sequential(9);
        step(1'b0, 1'b0, 2'b10, 1'b0, 16'h0, 26'h000_0C40, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if (pc_f !== 32'h3100 || instr_d !== imem(32'h3024) || pc_d !== 32'h3024 || pc8_d !== e.pc8_d) begin
            n_bad++;
            $display("FAIL jump: got pc_f=%h pc_d=%h instr_d=%h pc8_d=%h want %h %h %h %h",
                     pc_f, pc_d, instr_d, pc8_d, 32'h3100, 32'h3024, imem(32'h3024), e.pc8_d);
        end
    endtask

    task automatic test_stall_jr();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, (i < 2), 2'b11, 1'b0, 16'h0, 26'h0, 32'h3400);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_f, pc_d, instr_d, adel_f} !== {e.pc_f, e.pc_d, e.instr_d, e.adel_f}) begin
                n_bad++;
                $display("FAIL stall_jr[%0d]: got pc_f=%h pc_d=%h instr_d=%h adel=%b want %h %h %h %b",
                         i, pc_f, pc_d, instr_d, adel_f, e.pc_f, e.pc_d, e.instr_d, e.adel_f);
            end
        end
    endtask

    task automatic test_addr_check();
        logic [31:0] tgt[5];
        tgt[0] = 32'h3402; tgt[1] = 32'h7000; tgt[2] = 32'h6FFC;
        tgt[3] = 32'h2FFC; tgt[4] = 32'hFFFF_FFFC;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 2'b11, 1'b0, 16'h0, 26'h0, tgt[i]);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_f, adel_f} !== {e.pc_f, e.adel_f}) begin
                n_bad++;
                $display("FAIL addr_check[%0d]: got pc_f=%h adel=%b want %h %b",
                         i, pc_f, adel_f, e.pc_f, e.adel_f);
            end
        end
        // pc_f is 0xFFFF_FFFC here: sequential fetch wraps to zero.
        step(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if ({pc_f, pc_d, adel_f} !== {32'h0, 32'hFFFF_FFFC, e.adel_f}) begin
            n_bad++;
            $display("FAIL wrap: got pc_f=%h pc_d=%h adel=%b want %h %h %b",
                     pc_f, pc_d, adel_f, 32'h0, 32'hFFFF_FFFC, e.adel_f);
        end
    endtask

    task automatic test_reset_override();
        test_sequential(2);
        step(1'b1, 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h4444);
        e = sb.pop_front();
        n_cmp++;
        if ({pc_f, pc_d, instr_d} !== {32'h3000, 32'h3000, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_override: got pc_f=%h pc_d=%h instr_d=%h want %h %h %h",
                     pc_f, pc_d, instr_d, 32'h3000, 32'h3000, 32'h0);
        end
        test_sequential(2);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; npc_op = 2'b00; br_true = 1'b0;
        imm16 = 16'h0; instr_index = 26'h0; jr_addr = 32'h0;
        m_pc_f = 32'h0; m_pc_d = 32'h0; m_instr_d = 32'h0;
        #2;
        test_reset();
        test_sequential(3);
        test_branch();
        test_jump();
        test_stall_jr();
        test_addr_check();
        test_reset_override();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
